// File: rtl/playerl_ctl.sv
// playerl_ctl: once-per-frame motion, guard, thrust and death controller for
// the left player. Game state advances only on the vsync rising-edge tick so
// that every output stays constant for the whole visible frame. A hit pulse
// can arrive on any clock; it is parked in a sticky flag until the next tick.
module playerl_ctl #(
    parameter int X_MAX       = 810,
    parameter int WALK_STEP   = 4,
    parameter int JUMP_H      = 96,
    parameter int JUMP_STEP   = 8,
    parameter int LEG_PERIOD  = 8,
    parameter int SWORD_STEP  = 10,
    parameter int THRUST_LEN  = 24,
    parameter int THRUST_STEP = 4,
    parameter int DEAD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_jump,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_thrust,
    input  logic        hit_L,
    output logic [11:0] LP_x_pos,
    output logic [11:0] LP_y_pos,
    output logic        change_legs_L,
    output logic [4:0]  LP_sword_pos,
    output logic [11:0] LP_x_sword_pos,
    output logic        dead_L
);

    localparam int DCW = $clog2(DEAD_FRAMES + 1);
    localparam int LCW = $clog2(LEG_PERIOD + 1);

    // 13-bit working constants so sums and differences never wrap silently
    localparam logic [12:0] X_MAX_W       = 13'(X_MAX);
    localparam logic [12:0] WALK_STEP_W   = 13'(WALK_STEP);
    localparam logic [12:0] JUMP_H_W      = 13'(JUMP_H);
    localparam logic [12:0] JUMP_STEP_W   = 13'(JUMP_STEP);
    localparam logic [12:0] THRUST_LEN_W  = 13'(THRUST_LEN);
    localparam logic [12:0] THRUST_STEP_W = 13'(THRUST_STEP);

    localparam logic [11:0] X_MAX_O      = 12'(X_MAX);
    localparam logic [11:0] JUMP_H_O     = 12'(JUMP_H);
    localparam logic [11:0] THRUST_LEN_O = 12'(THRUST_LEN);

    localparam logic [LCW-1:0] LEG_LAST  = LCW'(LEG_PERIOD - 1);
    localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_WALK,
        ST_RISE,
        ST_FALL,
        ST_THRUST,
        ST_DEAD
    } state_t;

    state_t         state_reg, state_next;
    logic           vsync_d_reg;
    logic           tick;

    // edge-triggered keys packed as {thrust, down, up, jump}
    logic [3:0]     key_vec;
    logic [3:0]     key_prev_reg;
    logic [3:0]     key_edge;
    logic           jump_edge, up_edge, down_edge, thrust_edge;

    logic           hit_pend_reg, hit_pend_next;
    logic           extend_reg, extend_next;
    logic [LCW-1:0] leg_cnt_reg, leg_cnt_next;
    logic [DCW-1:0] dead_cnt_reg, dead_cnt_next;
    logic [1:0]     guard_reg, guard_next, guard_upd;
    logic [11:0]    x_reg, x_next;
    logic [11:0]    y_reg, y_next;
    logic [11:0]    xs_reg, xs_next;
    logic [4:0]     sword_reg, sword_next;
    logic           legs_reg, legs_next;
    logic           dead_reg, dead_next;

    // position arithmetic, 13 bits wide before clamping to 12
    logic [12:0]    x_wide, x_inc_raw, x_dec_raw;
    logic [11:0]    x_inc, x_dec, x_moved;
    logic           moving;
    logic [12:0]    y_wide, y_up_raw, y_dn_raw;
    logic [11:0]    y_up, y_dn;
    logic [12:0]    xs_wide, xs_ext_raw, xs_ret_raw;
    logic [11:0]    xs_ext, xs_ret;

    assign tick = vsync_in & ~vsync_d_reg;

    assign key_vec     = {key_thrust, key_down, key_up, key_jump};
    assign key_edge    = key_vec & ~key_prev_reg;
    assign jump_edge   = key_edge[0];
    assign up_edge     = key_edge[1];
    assign down_edge   = key_edge[2];
    assign thrust_edge = key_edge[3];

    // Horizontal step: right adds, left subtracts, a borrow out of the
    // 13-bit difference means we would have gone below zero.
    assign x_wide    = {1'b0, x_reg};
    assign x_inc_raw = x_wide + WALK_STEP_W;
    assign x_dec_raw = x_wide - WALK_STEP_W;
    assign x_inc     = (x_inc_raw > X_MAX_W) ? X_MAX_O : x_inc_raw[11:0];
    assign x_dec     = x_dec_raw[12] ? 12'd0 : x_dec_raw[11:0];
    assign x_moved   = (key_right & ~key_left) ? x_inc :
                       (key_left & ~key_right) ? x_dec : x_reg;
    // a clamped step that lands on the same spot is not motion
    assign moving    = (x_moved != x_reg);

    // Vertical jump arithmetic
    assign y_wide    = {1'b0, y_reg};
    assign y_up_raw  = y_wide + JUMP_STEP_W;
    assign y_dn_raw  = y_wide - JUMP_STEP_W;
    assign y_up      = (y_up_raw >= JUMP_H_W) ? JUMP_H_O : y_up_raw[11:0];
    assign y_dn      = y_dn_raw[12] ? 12'd0 : y_dn_raw[11:0];

    // Thrust extension arithmetic
    assign xs_wide    = {1'b0, xs_reg};
    assign xs_ext_raw = xs_wide + THRUST_STEP_W;
    assign xs_ret_raw = xs_wide - THRUST_STEP_W;
    assign xs_ext     = (xs_ext_raw >= THRUST_LEN_W) ? THRUST_LEN_O : xs_ext_raw[11:0];
    assign xs_ret     = xs_ret_raw[12] ? 12'd0 : xs_ret_raw[11:0];

    // Guard level request from this frame's up/down presses, saturating 0..2
    always_comb begin
        guard_upd = guard_reg;
        if (up_edge && !down_edge && guard_reg != 2'd2) begin
            guard_upd = guard_reg + 2'd1;
        end else if (down_edge && !up_edge && guard_reg != 2'd0) begin
            guard_upd = guard_reg - 2'd1;
        end
    end

    // Next-state and next-output logic, evaluated once per frame tick
    always_comb begin
        state_next    = state_reg;
        hit_pend_next = hit_pend_reg;
        extend_next   = extend_reg;
        leg_cnt_next  = leg_cnt_reg;
        dead_cnt_next = dead_cnt_reg;
        guard_next    = guard_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        xs_next       = xs_reg;
        legs_next     = legs_reg;
        dead_next     = dead_reg;

        if (tick) begin
            hit_pend_next = 1'b0;
            if (hit_pend_reg) begin
                // a struck player freezes where he stands
                state_next    = ST_DEAD;
                dead_next     = 1'b1;
                dead_cnt_next = '0;
                xs_next       = 12'd0;
                extend_next   = 1'b0;
            end else begin
                case (state_reg)
                    ST_WALK: begin
                        x_next     = x_moved;
                        guard_next = guard_upd;
                        if (moving) begin
                            if (leg_cnt_reg == LEG_LAST) begin
                                legs_next    = ~legs_reg;
                                leg_cnt_next = '0;
                            end else begin
                                leg_cnt_next = leg_cnt_reg + 1'b1;
                            end
                        end else begin
                            leg_cnt_next = '0;
                            legs_next    = 1'b0;
                        end
                        if (jump_edge) begin
                            state_next = ST_RISE;
                        end else if (thrust_edge) begin
                            state_next  = ST_THRUST;
                            extend_next = 1'b1;
                        end
                    end
                    ST_RISE: begin
                        x_next     = x_moved;
                        guard_next = guard_upd;
                        y_next     = y_up;
                        if (y_up == JUMP_H_O) begin
                            state_next = ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        x_next     = x_moved;
                        guard_next = guard_upd;
                        y_next     = y_dn;
                        if (y_dn == 12'd0) begin
                            state_next = ST_WALK;
                        end
                    end
                    ST_THRUST: begin
                        if (extend_reg) begin
                            xs_next = xs_ext;
                            if (xs_ext == THRUST_LEN_O) begin
                                extend_next = 1'b0;
                            end
                        end else begin
                            xs_next = xs_ret;
                            if (xs_ret == 12'd0) begin
                                state_next = ST_WALK;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt_reg == DEAD_LAST) begin
                            state_next   = ST_WALK;
                            dead_next    = 1'b0;
                            x_next       = 12'd0;
                            y_next       = 12'd0;
                            guard_next   = 2'd0;
                            legs_next    = 1'b0;
                            leg_cnt_next = '0;
                        end else begin
                            dead_cnt_next = dead_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_WALK;
                    end
                endcase
            end
        end

        // a hit arriving on a tick clock is kept for the following tick
        if (hit_L && state_reg != ST_DEAD && !(tick && hit_pend_reg)) begin
            hit_pend_next = 1'b1;
        end

        sword_next = 5'(int'(guard_next) * SWORD_STEP);
    end

    // Frame-tick edge detector: remembers last clock's vsync level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d_reg <= 1'b0;
        end else begin
            vsync_d_reg <= vsync_in;
        end
    end

    // Per-frame key sampling for press-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev_reg <= 4'b0000;
        end else if (tick) begin
            key_prev_reg <= key_vec;
        end
    end

    // Game-state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_WALK;
            hit_pend_reg <= 1'b0;
            extend_reg   <= 1'b0;
            leg_cnt_reg  <= '0;
            dead_cnt_reg <= '0;
            guard_reg    <= 2'd0;
            x_reg        <= 12'd0;
            y_reg        <= 12'd0;
            xs_reg       <= 12'd0;
            sword_reg    <= 5'd0;
            legs_reg     <= 1'b0;
            dead_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hit_pend_reg <= hit_pend_next;
            extend_reg   <= extend_next;
            leg_cnt_reg  <= leg_cnt_next;
            dead_cnt_reg <= dead_cnt_next;
            guard_reg    <= guard_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            xs_reg       <= xs_next;
            sword_reg    <= sword_next;
            legs_reg     <= legs_next;
            dead_reg     <= dead_next;
        end
    end

    assign LP_x_pos       = x_reg;
    assign LP_y_pos       = y_reg;
    assign change_legs_L  = legs_reg;
    assign LP_sword_pos   = sword_reg;
    assign LP_x_sword_pos = xs_reg;
    assign dead_L         = dead_reg;

endmodule

// File: tb/tb_playerl_ctl.sv
// tb_playerl_ctl: table vectors, hand-written multi-frame sequences and a
// randomized run compared against a frame-level model of the left player.
module tb_playerl_ctl;

    localparam int X_MAX       = 810;
    localparam int WALK_STEP   = 4;
    localparam int JUMP_H      = 96;
    localparam int JUMP_STEP   = 8;
    localparam int LEG_PERIOD  = 8;
    localparam int SWORD_STEP  = 10;
    localparam int THRUST_LEN  = 24;
    localparam int THRUST_STEP = 4;
    localparam int DEAD_FRAMES = 120;
    localparam int JF = JUMP_H / JUMP_STEP;
    localparam int TF = THRUST_LEN / THRUST_STEP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0;
    logic        key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
    logic        key_up = 1'b0, key_down = 1'b0, key_thrust = 1'b0;
    logic        hit_L = 1'b0;
    logic [11:0] LP_x_pos, LP_y_pos, LP_x_sword_pos;
    logic        change_legs_L, dead_L;
    logic [4:0]  LP_sword_pos;

    playerl_ctl dut (
        .clk            (clk),
        .reset          (reset),
        .vsync_in       (vsync_in),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_jump       (key_jump),
        .key_up         (key_up),
        .key_down       (key_down),
        .key_thrust     (key_thrust),
        .hit_L          (hit_L),
        .LP_x_pos       (LP_x_pos),
        .LP_y_pos       (LP_y_pos),
        .change_legs_L  (change_legs_L),
        .LP_sword_pos   (LP_sword_pos),
        .LP_x_sword_pos (LP_x_sword_pos),
        .dead_L         (dead_L)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- frame-level reference model ----------------
    int m_x, m_y, m_level, m_legs, m_xs, m_dead;
    int m_run, m_air, m_th, m_dt;
    bit m_in_air, m_in_th, m_hit;
    bit m_pj, m_pu, m_pd, m_pt;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_level = 0; m_legs = 0; m_xs = 0; m_dead = 0;
        m_run = 0; m_air = 0; m_th = 0; m_dt = 0;
        m_in_air = 0; m_in_th = 0; m_hit = 0;
        m_pj = 0; m_pu = 0; m_pd = 0; m_pt = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j,
                               input bit u, input bit d, input bit t);
        bit ej, eu, ed, et, moved;
        int nx;
        ej = j && !m_pj; eu = u && !m_pu; ed = d && !m_pd; et = t && !m_pt;
        m_pj = j; m_pu = u; m_pd = d; m_pt = t;
        if (m_hit) begin
            m_hit = 0; m_dead = 1; m_dt = 0; m_xs = 0;
            m_in_air = 0; m_in_th = 0;
        end else if (m_dead != 0) begin
            m_dt++;
            if (m_dt == DEAD_FRAMES) begin
                m_dead = 0; m_x = 0; m_y = 0; m_level = 0; m_legs = 0; m_run = 0;
            end
        end else if (m_in_th) begin
            m_th++;
            m_xs = THRUST_STEP * imin(m_th, 2 * TF - m_th);
            if (m_th == 2 * TF) m_in_th = 0;
        end else begin
            nx = m_x;
            if (r && !l) nx = imin(m_x + WALK_STEP, X_MAX);
            else if (l && !r) nx = (m_x - WALK_STEP < 0) ? 0 : m_x - WALK_STEP;
            moved = (nx != m_x);
            m_x = nx;
            if (eu && !ed) m_level = imin(m_level + 1, 2);
            else if (ed && !eu) m_level = (m_level > 0) ? m_level - 1 : 0;
            if (m_in_air) begin
                m_air++;
                m_y = JUMP_STEP * imin(m_air, 2 * JF - m_air);
                if (m_air == 2 * JF) m_in_air = 0;
            end else begin
                if (moved) m_run++;
                else m_run = 0;
                m_legs = (m_run / LEG_PERIOD) % 2;
                if (ej) begin
                    m_in_air = 1; m_air = 0;
                end else if (et) begin
                    m_in_th = 1; m_th = 0;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic frame(input bit l, input bit r, input bit j,
                         input bit u, input bit d, input bit t);
        @(negedge clk);
        key_left = l; key_right = r; key_jump = j;
        key_up = u; key_down = d; key_thrust = t;
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        model_frame(l, r, j, u, d, t);
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        hit_L = 1'b1;
        @(negedge clk);
        hit_L = 1'b0;
        if (m_dead == 0) m_hit = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        key_left = 0; key_right = 0; key_jump = 0;
        key_up = 0; key_down = 0; key_thrust = 0;
        hit_L = 0; vsync_in = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_x"}, int'(LP_x_pos), m_x);
        chk({tag, "_y"}, int'(LP_y_pos), m_y);
        chk({tag, "_legs"}, int'(change_legs_L), m_legs);
        chk({tag, "_sword"}, int'(LP_sword_pos), m_level * SWORD_STEP);
        chk({tag, "_xsword"}, int'(LP_x_sword_pos), m_xs);
        chk({tag, "_dead"}, int'(dead_L), m_dead);
    endtask

    typedef struct {
        bit r, l, j, u, d, t;
        int x, y, sp, xs;
    } vec_t;

    vec_t vecs[18];

    initial begin
        bit rr, ll, jj, uu, dd, tt;

        vecs[0]  = '{0,0,0,0,0,0,   0, 0,  0, 0};
        vecs[1]  = '{1,0,0,0,0,0,   4, 0,  0, 0};
        vecs[2]  = '{1,1,0,0,0,0,   4, 0,  0, 0};
        vecs[3]  = '{0,1,0,0,0,0,   0, 0,  0, 0};
        vecs[4]  = '{0,1,0,0,0,0,   0, 0,  0, 0};
        vecs[5]  = '{0,0,0,1,0,0,   0, 0, 10, 0};
        vecs[6]  = '{0,0,0,1,0,0,   0, 0, 10, 0};
        vecs[7]  = '{0,0,0,0,0,0,   0, 0, 10, 0};
        vecs[8]  = '{0,0,0,1,0,0,   0, 0, 20, 0};
        vecs[9]  = '{0,0,0,0,0,0,   0, 0, 20, 0};
        vecs[10] = '{0,0,0,1,0,0,   0, 0, 20, 0};
        vecs[11] = '{0,0,0,0,0,0,   0, 0, 20, 0};
        vecs[12] = '{0,0,0,1,1,0,   0, 0, 20, 0};
        vecs[13] = '{0,0,0,0,0,0,   0, 0, 20, 0};
        vecs[14] = '{0,0,0,0,1,0,   0, 0, 10, 0};
        vecs[15] = '{1,0,0,0,0,1,   4, 0, 10, 0};
        vecs[16] = '{1,0,0,0,0,0,   4, 0, 10, 4};
        vecs[17] = '{1,0,0,1,0,0,   4, 0, 10, 8};

        // reset state
        do_reset();
        chk("reset_x", int'(LP_x_pos), 0);
        chk("reset_dead", int'(dead_L), 0);
        chk("reset_sword", int'(LP_sword_pos), 0);

        // table vectors, applied back to back from reset
        for (int i = 0; i < 18; i++) begin
            frame(vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].u, vecs[i].d, vecs[i].t);
            $display("vec %0d: x=%0d y=%0d sp=%0d xs=%0d", i, LP_x_pos, LP_y_pos,
                     LP_sword_pos, LP_x_sword_pos);
            chk($sformatf("vec%0d_x", i), int'(LP_x_pos), vecs[i].x);
            chk($sformatf("vec%0d_y", i), int'(LP_y_pos), vecs[i].y);
            chk($sformatf("vec%0d_sp", i), int'(LP_sword_pos), vecs[i].sp);
            chk($sformatf("vec%0d_xs", i), int'(LP_x_sword_pos), vecs[i].xs);
        end

        // walking, leg animation and asynchronous reset
        do_reset();
        for (int f = 1; f <= 10; f++) begin
            frame(0, 1, 0, 0, 0, 0);
            if (f == 7)  chk("legs_f7", int'(change_legs_L), 0);
            if (f == 8)  chk("legs_f8", int'(change_legs_L), 1);
            if (f == 10) chk("walk10_x", int'(LP_x_pos), 40);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            int'({LP_x_pos, LP_y_pos, change_legs_L, LP_sword_pos, LP_x_sword_pos, dead_L}), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int f = 1; f <= 16; f++) begin
            frame(0, 1, 0, 0, 0, 0);
            if (f == 15) chk("legs_f15", int'(change_legs_L), 1);
            if (f == 16) chk("legs_f16", int'(change_legs_L), 0);
        end

        // right-edge saturation
        do_reset();
        for (int f = 0; f < 202; f++) frame(0, 1, 0, 0, 0, 0);
        chk("sat_808", int'(LP_x_pos), 808);
        frame(0, 1, 0, 0, 0, 0);
        chk("sat_810", int'(LP_x_pos), 810);
        frame(0, 1, 0, 0, 0, 0);
        chk("sat_hold", int'(LP_x_pos), 810);
        frame(1, 0, 0, 0, 0, 0);
        chk("sat_back", int'(LP_x_pos), 806);

        // jump arc, second press while airborne ignored
        do_reset();
        frame(0, 0, 1, 0, 0, 0);
        chk("jump_entry_y", int'(LP_y_pos), 0);
        for (int i = 1; i <= 24; i++) begin
            frame(0, 0, (i == 5), 0, 0, 0);
            chk($sformatf("jump_y%0d", i), int'(LP_y_pos), 8 * imin(i, 24 - i));
        end
        frame(0, 0, 0, 0, 0, 0);
        chk("jump_landed", int'(LP_y_pos), 0);
        frame(0, 0, 1, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0);
        chk("jump_again", int'(LP_y_pos), 8);

        // thrust with right held: sword profile, no motion
        do_reset();
        frame(0, 1, 0, 0, 0, 0);
        frame(0, 1, 0, 0, 0, 1);
        chk("thrust_entry_x", int'(LP_x_pos), 8);
        for (int i = 1; i <= 12; i++) begin
            frame(0, 1, 0, 0, 0, 0);
            chk($sformatf("thrust_xs%0d", i), int'(LP_x_sword_pos), 4 * imin(i, 12 - i));
            chk($sformatf("thrust_x%0d", i), int'(LP_x_pos), 8);
        end
        frame(0, 1, 0, 0, 0, 0);
        chk("thrust_done_x", int'(LP_x_pos), 12);

        // hit mid-thrust, death timer, hit during death ignored
        do_reset();
        for (int f = 0; f < 25; f++) frame(0, 1, 0, 0, 0, 0);
        frame(0, 0, 0, 1, 0, 0);
        frame(0, 0, 0, 0, 0, 1);
        frame(0, 0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0);
        chk("pre_hit_xs", int'(LP_x_sword_pos), 8);
        hit_pulse();
        chk("hit_not_before_tick", int'(dead_L), 0);
        frame(0, 0, 0, 0, 0, 0);
        chk("hit_dead", int'(dead_L), 1);
        chk("hit_xs", int'(LP_x_sword_pos), 0);
        chk("hit_x", int'(LP_x_pos), 100);
        chk("hit_sp", int'(LP_sword_pos), 10);
        for (int i = 1; i <= 120; i++) begin
            if (i == 50) hit_pulse();
            frame(0, 1, 0, 0, 0, 0);
            if (i == 119) begin
                chk("dead_119", int'(dead_L), 1);
                chk("dead_x_frozen", int'(LP_x_pos), 100);
            end
            if (i == 120) begin
                chk("respawn_dead", int'(dead_L), 0);
                chk("respawn_x", int'(LP_x_pos), 0);
                chk("respawn_sp", int'(LP_sword_pos), 0);
            end
        end
        frame(0, 0, 0, 0, 0, 0);
        chk("ignored_hit", int'(dead_L), 0);

        // randomized frames against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(59) == 0) hit_pulse();
            rr = ($urandom_range(1) == 1);
            ll = ($urandom_range(3) == 0);
            jj = ($urandom_range(9) == 0);
            uu = ($urandom_range(5) == 0);
            dd = ($urandom_range(5) == 0);
            tt = ($urandom_range(9) == 0);
            frame(ll, rr, jj, uu, dd, tt);
            $display("rand %0d: keys l%0d r%0d j%0d u%0d d%0d t%0d -> x=%0d y=%0d legs=%0d sp=%0d xs=%0d dead=%0d",
                     n, ll, rr, jj, uu, dd, tt, LP_x_pos, LP_y_pos, change_legs_L,
                     LP_sword_pos, LP_x_sword_pos, dead_L);
            chk_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
